// File: rtl/calc_sequencer_if.sv
// Keypad token, ALU handshake and display signals around the calculator sequencer.
// master is the sequencer side; slave is the keypad/ALU/display side.
interface calc_sequencer_if;
  logic [3:0]  num_val;
  logic [1:0]  op_val;
  logic        is_num;
  logic        is_op;
  logic        is_eq;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] data_out_bcd;
  logic        busy;
  logic        err;

  modport master (
    input  num_val, op_val, is_num, is_op, is_eq, alu_done, alu_result, alu_err,
    output alu_start, alu_op, alu_a, alu_b, data_out_bcd, busy, err
  );

  modport slave (
    output num_val, op_val, is_num, is_op, is_eq, alu_done, alu_result, alu_err,
    input  alu_start, alu_op, alu_a, alu_b, data_out_bcd, busy, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Control FSM between the keypad token decoder and the BCD ALU: collects A, op and B,
// launches the ALU on '=', and presents the result (or EEEE on error) to the display.
module calc_sequencer #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  calc_sequencer_if.master bus
);
  localparam int unsigned     CntW    = $clog2(DIGITS + 1);
  localparam int unsigned     TmoW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax  = CntW'(DIGITS);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [15:0]     ErrCode = 16'hEEEE;

  typedef enum logic [2:0] {StA, StOp, StB, StCalc, StRes} state_e;

  state_e          state_q;
  logic [15:0]     a_q, b_q, r_q, disp_q;
  logic [CntW-1:0] cnt_a_q, cnt_b_q;
  logic [TmoW-1:0] tmo_q;
  logic [1:0]      op_q;
  logic            start_q, busy_q, err_q;

  logic            digit_ok;
  logic            a_take, b_take;
  logic [15:0]     a_shift, b_shift, digit_ext;

  assign digit_ok  = bus.num_val <= 4'd9;
  assign a_shift   = {a_q[11:0], bus.num_val};
  assign b_shift   = {b_q[11:0], bus.num_val};
  assign digit_ext = {12'h000, bus.num_val};
  // A leading zero on an empty operand is swallowed so it does not consume a digit slot.
  assign a_take    = (cnt_a_q != CntMax) && !((cnt_a_q == '0) && (bus.num_val == 4'd0));
  assign b_take    = (cnt_b_q != CntMax) && !((cnt_b_q == '0) && (bus.num_val == 4'd0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StA;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      disp_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      tmo_q   <= '0;
      op_q    <= 2'b00;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StA: begin
          if (bus.is_num) begin
            if (digit_ok && a_take) begin
              a_q     <= a_shift;
              cnt_a_q <= cnt_a_q + 1'b1;
              disp_q  <= a_shift;
            end
          end else if (bus.is_op) begin
            op_q    <= bus.op_val;
            state_q <= StOp;
          end
        end
        StOp: begin
          if (bus.is_num) begin
            if (digit_ok) begin
              b_q     <= digit_ext;
              cnt_b_q <= CntOne;
              disp_q  <= digit_ext;
              state_q <= StB;
            end
          end else if (bus.is_op) begin
            op_q <= bus.op_val;
          end
        end
        StB: begin
          if (bus.is_num) begin
            if (digit_ok && b_take) begin
              b_q     <= b_shift;
              cnt_b_q <= cnt_b_q + 1'b1;
              disp_q  <= b_shift;
            end
          end else if (bus.is_eq && !bus.is_op) begin
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          // alu_done is tested first so a reply on the timeout edge still counts.
          if (bus.alu_done) begin
            busy_q  <= 1'b0;
            state_q <= StRes;
            if (bus.alu_err) begin
              err_q  <= 1'b1;
              disp_q <= ErrCode;
            end else begin
              r_q    <= bus.alu_result;
              disp_q <= bus.alu_result;
            end
          end else if (tmo_q == TmoLast) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            disp_q  <= ErrCode;
            state_q <= StRes;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StRes: begin
          if (bus.is_num) begin
            if (digit_ok) begin
              err_q   <= 1'b0;
              a_q     <= digit_ext;
              cnt_a_q <= CntOne;
              b_q     <= '0;
              cnt_b_q <= '0;
              disp_q  <= digit_ext;
              state_q <= StA;
            end
          end else if (bus.is_op && !err_q) begin
            // Chaining: the previous result becomes operand A.
            a_q     <= r_q;
            cnt_a_q <= CntMax;
            op_q    <= bus.op_val;
            disp_q  <= r_q;
            state_q <= StOp;
          end
        end
        default: state_q <= StA;
      endcase
    end
  end

  assign bus.alu_start    = start_q;
  assign bus.alu_op       = op_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.data_out_bcd = disp_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Randomised bench for calc_sequencer: operands are modelled as decimal integers and every
// output is compared each cycle against that model; a stub ALU answers with real arithmetic.
module tb_calc_sequencer;
  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_sequencer_if bus ();

  calc_sequencer #(
    .DIGITS  (DIGITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec     = 0;
  int n_miscmp  = 0;

  typedef enum {MEntA, MEntOp, MEntB, MWait, MShow} phase_e;
  phase_e      m_ph;
  int          m_a, m_b, m_na, m_nb, m_cyc, m_t0;
  logic [1:0]  m_op;
  logic [15:0] m_r;
  bit          m_err, m_start;

  int          stub_cd;
  bit          stub_never, stub_fail;
  logic [15:0] stub_res;
  bit          force_on;
  int          force_kind, force_lat;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] exp_disp();
    case (m_ph)
      MEntA, MEntOp: return to_bcd(m_a);
      MEntB, MWait:  return to_bcd(m_b);
      default:       return m_err ? 16'hEEEE : m_r;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("alu_start", 16'(bus.alu_start), 16'(m_start));
    check("alu_op", 16'(bus.alu_op), 16'(m_op));
    check("alu_a", bus.alu_a, to_bcd(m_a));
    check("alu_b", bus.alu_b, to_bcd(m_b));
    check("display", bus.data_out_bcd, exp_disp());
    check("busy", 16'(bus.busy), 16'(m_ph == MWait));
    check("err", 16'(bus.err), 16'(m_err));
  endtask

  task automatic model_reset();
    m_ph = MEntA; m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
    m_op = 2'b00; m_r = '0; m_err = 0; m_start = 0;
  endtask

  task automatic model_edge(input bit num, input int nv, input bit op, input logic [1:0] ov,
                            input bit eq, input bit done, input bit aerr, input logic [15:0] res);
    m_start = 0;
    case (m_ph)
      MEntA:
        if (num) begin
          if (nv <= 9 && m_na < DIGITS && !(m_na == 0 && nv == 0)) begin
            m_a = m_a * 10 + nv; m_na++;
          end
        end else if (op) begin
          m_op = ov; m_ph = MEntOp;
        end
      MEntOp:
        if (num) begin
          if (nv <= 9) begin m_b = nv; m_nb = 1; m_ph = MEntB; end
        end else if (op) begin
          m_op = ov;
        end
      MEntB:
        if (num) begin
          if (nv <= 9 && m_nb < DIGITS && !(m_nb == 0 && nv == 0)) begin
            m_b = m_b * 10 + nv; m_nb++;
          end
        end else if (!op && eq) begin
          m_start = 1; m_t0 = m_cyc; m_ph = MWait;
        end
      MWait:
        if (done) begin
          m_err = aerr;
          if (!aerr) m_r = res;
          m_ph = MShow;
        end else if (m_cyc - m_t0 == TIMEOUT) begin
          m_err = 1; m_ph = MShow;
        end
      default:
        if (num) begin
          if (nv <= 9) begin
            m_err = 0; m_a = nv; m_na = 1; m_b = 0; m_nb = 0; m_ph = MEntA;
          end
        end else if (op && !m_err) begin
          m_a = from_bcd(m_r); m_op = ov; m_ph = MEntOp;
        end
    endcase
  endtask

  // Stub ALU: computes the true answer; kind 0 answers, 1 reports error, 2 never answers.
  task automatic arm_stub();
    int r, kind, lat;
    bit bad;
    case (m_op)
      2'd0:    r = m_a + m_b;
      2'd1:    r = m_a - m_b;
      2'd2:    r = m_a * m_b;
      default: r = (m_b == 0) ? -1 : m_a / m_b;
    endcase
    bad = (r < 0) || (r > 9999);
    if (force_on) begin
      kind = force_kind; lat = force_lat; force_on = 0;
    end else begin
      kind = ($urandom_range(0, 9) < 2) ? 2 : (($urandom_range(0, 9) == 0) ? 1 : 0);
      lat  = $urandom_range(1, TIMEOUT + 2);
    end
    stub_never = (kind == 2);
    stub_fail  = (kind == 1) || bad;
    stub_res   = bad ? 16'h1111 : to_bcd(r);
    stub_cd    = lat;
  endtask

  task automatic step(input bit num = 0, input int nv = 0, input bit op = 0, input int ov = 0,
                      input bit eq = 0);
    bus.is_num     = num;
    bus.num_val    = 4'(nv);
    bus.is_op      = op;
    bus.op_val     = 2'(ov);
    bus.is_eq      = eq;
    bus.alu_done   = 1'b0;
    bus.alu_err    = 1'b0;
    bus.alu_result = '0;
    if (stub_cd > 0) begin
      stub_cd--;
      if (stub_cd == 0 && !stub_never) begin
        bus.alu_done   = 1'b1;
        bus.alu_err    = stub_fail;
        bus.alu_result = stub_fail ? 16'h1111 : stub_res;
      end
    end
    @(posedge clk);
    m_cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      model_edge(num, nv, op, 2'(ov), eq, bus.alu_done, bus.alu_err, bus.alu_result);
      if (m_start) arm_stub();
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int k, nv, ov;
    bit num, op, eq;
    model_reset();
    m_cyc = 0; m_t0 = 0; stub_cd = 0; force_on = 0;

    rst = 1'b0; step(); step();
    check("rst_display", bus.data_out_bcd, 16'h0000);
    rst = 1'b1;

    // 1 + basic calculation, 5-cycle ALU latency.
    force_on = 1; force_kind = 0; force_lat = 5;
    step(1, 1); step(1, 2); step(0, 0, 1, 0); step(1, 3); step(0, 0, 0, 0, 1);
    check("t1_start", 16'(bus.alu_start), 16'd1);
    check("t1_a", bus.alu_a, 16'h0012);
    check("t1_b", bus.alu_b, 16'h0003);
    check("t1_op", 16'(bus.alu_op), 16'd0);
    repeat (4) step();
    check("t1_busy_held", 16'(bus.busy), 16'd1);
    step();
    check("t1_busy_done", 16'(bus.busy), 16'd0);
    check("t1_result", bus.data_out_bcd, 16'h0015);

    // Chaining from the shown result.
    force_on = 1; force_kind = 0; force_lat = 3;
    step(0, 0, 1, 2); step(1, 2); step(0, 0, 0, 0, 1);
    check("t3_a", bus.alu_a, 16'h0015);
    check("t3_b", bus.alu_b, 16'h0002);
    check("t3_op", 16'(bus.alu_op), 16'd2);
    repeat (3) step();
    check("t3_result", bus.data_out_bcd, 16'h0030);

    // ALU silent: timeout exactly TIMEOUT cycles after alu_start.
    step(1, 5); step(0, 0, 1, 0); step(1, 1);
    force_on = 1; force_kind = 2; force_lat = 1;
    step(0, 0, 0, 0, 1);
    repeat (TIMEOUT - 1) step();
    check("t4_err_early", 16'(bus.err), 16'd0);
    step();
    check("t4_err", 16'(bus.err), 16'd1);
    check("t4_display", bus.data_out_bcd, 16'hEEEE);
    step(0, 0, 1, 1);
    check("t4_op_ignored", bus.data_out_bcd, 16'hEEEE);
    step(1, 4);
    check("t4_err_clr", 16'(bus.err), 16'd0);
    check("t4_digit", bus.data_out_bcd, 16'h0004);

    // Digit limit and leading zeros.
    rst = 1'b0; step(); rst = 1'b1;
    for (int d = 1; d <= 5; d++) step(1, d);
    check("t2_limit", bus.alu_a, 16'h1234);
    rst = 1'b0; step(); rst = 1'b1;
    step(1, 0); step(1, 0); step(1, 7);
    check("t2_lead0", bus.alu_a, 16'h0007);
    step(1, 1); step(1, 2); step(1, 3);
    check("t2_count", bus.alu_a, 16'h7123);

    // Token priority, invalid digit, '=' outside S_B.
    rst = 1'b0; step(); rst = 1'b1;
    step(1, 3, 1, 1);
    check("t5_num_wins", bus.alu_a, 16'h0003);
    check("t5_op_dropped", 16'(bus.alu_op), 16'd0);
    step(0, 0, 0, 0, 1);
    check("t5_eq_in_a", 16'(bus.alu_start), 16'd0);
    step(1, 10);
    check("t5_bad_digit", bus.alu_a, 16'h0003);
    step(0, 0, 1, 1); step(0, 0, 0, 0, 1);
    check("t5_eq_in_op", 16'(bus.alu_start), 16'd0);

    // Reset mid-calculation, then a late alu_done.
    step(1, 1);
    force_on = 1; force_kind = 0; force_lat = 6;
    step(0, 0, 0, 0, 1); step(); step();
    rst = 1'b0; step(); rst = 1'b1;
    repeat (5) step();
    check("t6_display", bus.data_out_bcd, 16'h0000);
    check("t6_busy", 16'(bus.busy), 16'd0);

    // Random token stream.
    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      k  = $urandom_range(0, 99);
      nv = $urandom_range(0, 9);
      ov = $urandom_range(0, 3);
      num = 0; op = 0; eq = 0;
      if (k < 40)      num = 1;
      else if (k < 45) begin num = 1; nv = $urandom_range(10, 15); end
      else if (k < 60) op = 1;
      else if (k < 75) eq = 1;
      else if (k < 80) begin num = 1; op = 1; end
      else if (k < 83) begin num = 1; eq = 1; end
      else if (k < 85) begin op = 1; eq = 1; end
      step(num, nv, op, ov, eq);
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
